// File: rtl/barrier_sequencer.sv
// barrier_sequencer: game-control FSM that issues one barrier lane at a time to the
// barrier generator, scores clean passes and counts down lives on collisions.
module barrier_sequencer #(
  parameter int unsigned LIVES_INIT      = 3,
  parameter int unsigned GAP_FRAMES      = 60,
  parameter int unsigned ACTIVE_FRAMES   = 120,
  parameter int unsigned HIT_HOLD_FRAMES = 30,
  parameter logic [15:0] LFSR_SEED       = 16'hACE1,
  parameter int unsigned SCORE_W         = 16
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_v_sync,
  input  logic               i_start,
  input  logic               i_penguin_hit,
  output logic [1:0]         o_active,
  output logic [2:0]         o_lives,
  output logic [SCORE_W-1:0] o_score,
  output logic               o_game_over,
  output logic [2:0]         o_state
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_GAP       = 3'd1,
    S_ACTIVE    = 3'd2,
    S_HIT_HOLD  = 3'd3,
    S_GAME_OVER = 3'd4
  } state_t;

  localparam logic [7:0]         GAP_LAST    = 8'(GAP_FRAMES - 1);
  localparam logic [7:0]         ACTIVE_LAST = 8'(ACTIVE_FRAMES - 1);
  localparam logic [7:0]         HOLD_LAST   = 8'(HIT_HOLD_FRAMES - 1);
  localparam logic [2:0]         LIVES_LOAD  = 3'(LIVES_INIT);
  localparam logic [15:0]        LFSR_TAPS   = 16'hB400;
  localparam logic [SCORE_W-1:0] SCORE_ONE   = SCORE_W'(1);

  state_t               state_q, state_d;
  logic [7:0]           cnt_q, cnt_d;
  logic [2:0]           lives_q, lives_d;
  logic [SCORE_W-1:0]   score_q, score_d;
  logic [1:0]           lane_q, lane_d;
  logic [1:0]           lane_raw, lane_pick;
  logic [1:0]           active_q, active_d;
  logic                 game_over_q, game_over_d;
  logic [15:0]          lfsr_q;
  logic                 v_sync_s1, v_sync_s2, v_sync_d, tick;

  // Two-flop synchroniser, edge detector and a registered tick pulse.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      v_sync_s1 <= 1'b0;
      v_sync_s2 <= 1'b0;
      v_sync_d  <= 1'b0;
      tick      <= 1'b0;
    end else begin
      v_sync_s1 <= i_v_sync;
      v_sync_s2 <= v_sync_s1;
      v_sync_d  <= v_sync_s2;
      tick      <= v_sync_s2 & ~v_sync_d;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : '0);
    end
  end

  // lane_q doubles as the previous-lane register for the no-repeat rule.
  always_comb begin
    lane_raw  = (lfsr_q[1:0] == 2'b00) ? 2'b10 : lfsr_q[1:0];
    lane_pick = lane_raw;
    if (lane_raw == lane_q) begin
      case (lane_raw)
        2'b01:   lane_pick = 2'b10;
        2'b10:   lane_pick = 2'b11;
        default: lane_pick = 2'b01;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      lives_q <= '0;
      score_q <= '0;
      lane_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lives_q <= lives_d;
      score_q <= score_d;
      lane_q  <= lane_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lives_d = lives_q;
    score_d = score_q;
    lane_d  = lane_q;
    case (state_q)
      S_IDLE, S_GAME_OVER: begin
        if (i_start) begin
          state_d = S_GAP;
          cnt_d   = '0;
          lives_d = LIVES_LOAD;
          score_d = '0;
        end
      end
      S_GAP: begin
        if (tick) begin
          if (cnt_q == GAP_LAST) begin
            state_d = S_ACTIVE;
            cnt_d   = '0;
            lane_d  = lane_pick;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      S_ACTIVE: begin
        // A hit pre-empts a timeout landing in the same cycle.
        if (i_penguin_hit) begin
          state_d = S_HIT_HOLD;
          cnt_d   = '0;
          lives_d = (lives_q == '0) ? '0 : lives_q - 3'd1;
        end else if (tick) begin
          if (cnt_q == ACTIVE_LAST) begin
            state_d = S_GAP;
            cnt_d   = '0;
            score_d = (score_q == '1) ? score_q : score_q + SCORE_ONE;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      S_HIT_HOLD: begin
        if (tick) begin
          if (cnt_q == HOLD_LAST) begin
            state_d = (lives_q == '0) ? S_GAME_OVER : S_GAP;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    active_d    = 2'b00;
    game_over_d = 1'b0;
    case (state_q)
      S_ACTIVE:    active_d    = lane_q;
      S_GAME_OVER: game_over_d = 1'b1;
      default:     ;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      active_q    <= '0;
      game_over_q <= 1'b0;
    end else begin
      active_q    <= active_d;
      game_over_q <= game_over_d;
    end
  end

  assign o_active    = active_q;
  assign o_lives     = lives_q;
  assign o_score     = score_q;
  assign o_game_over = game_over_q;
  assign o_state     = state_q;

endmodule

// File: tb/tb_barrier_sequencer.sv
// tb_barrier_sequencer: directed scenarios plus randomized frame timing and hits,
// checked every cycle against a frame-level reference model of the game rules.
module tb_barrier_sequencer;

  localparam int unsigned GAP   = 4;
  localparam int unsigned ACT   = 8;
  localparam int unsigned HOLD  = 2;
  localparam int unsigned LIVES = 3;
  localparam logic [15:0] SEED  = 16'hACE1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        v_sync = 1'b0;
  logic        start = 1'b0;
  logic        hit = 1'b0;
  logic [1:0]  o_active;
  logic [2:0]  o_lives;
  logic [15:0] o_score;
  logic        o_game_over;
  logic [2:0]  o_state;

  int unsigned checks = 0;
  int unsigned errors = 0;

  always #5 clk = ~clk;

  barrier_sequencer #(
    .LIVES_INIT(LIVES),
    .GAP_FRAMES(GAP),
    .ACTIVE_FRAMES(ACT),
    .HIT_HOLD_FRAMES(HOLD),
    .LFSR_SEED(SEED),
    .SCORE_W(16)
  ) dut (
    .i_clk(clk),
    .i_rst_n(rst_n),
    .i_v_sync(v_sync),
    .i_start(start),
    .i_penguin_hit(hit),
    .o_active(o_active),
    .o_lives(o_lives),
    .o_score(o_score),
    .o_game_over(o_game_over),
    .o_state(o_state)
  );

  // Reference model: game phase, frames seen in the phase, and a tick schedule
  // derived from the v_sync rises the bench itself drives.
  typedef enum int {M_IDLE = 0, M_GAP = 1, M_ACT = 2, M_HOLD = 3, M_OVER = 4} mphase_t;
  mphase_t         m_phase;
  int unsigned     m_frames, m_lives, m_lane, m_active;
  int unsigned     m_go;
  logic [15:0]     m_score;
  logic [15:0]     m_lfsr;
  bit              m_vprev;
  bit              edge_tick;
  longint unsigned m_edge;
  longint unsigned tick_at[$];
  int unsigned     tick_count = 0;
  bit              vs_fixed;
  int unsigned     vs_left;

  function automatic void model_reset();
    m_phase   = M_IDLE;
    m_frames  = 0;
    m_lives   = 0;
    m_score   = '0;
    m_lane    = 0;
    m_active  = 0;
    m_go      = 0;
    m_lfsr    = SEED;
    m_vprev   = 1'b0;
    edge_tick = 1'b0;
    m_edge    = 0;
    tick_at.delete();
  endfunction

  function automatic int unsigned pick_lane();
    int unsigned lane;
    lane = int'(m_lfsr[1:0]);
    if (lane == 0) lane = 2;
    if (lane == m_lane) lane = lane % 3 + 1;
    return lane;
  endfunction

  function automatic void model_step();
    int unsigned nxt_active;
    int unsigned nxt_go;
    if (!rst_n) begin
      model_reset();
      return;
    end
    edge_tick = (tick_at.size() != 0) && (tick_at[0] == m_edge);
    if (edge_tick) begin
      void'(tick_at.pop_front());
      tick_count++;
    end
    if (v_sync && !m_vprev) tick_at.push_back(m_edge + 3);
    m_vprev = v_sync;
    nxt_active = (m_phase == M_ACT) ? m_lane : 0;
    nxt_go     = (m_phase == M_OVER) ? 1 : 0;
    case (m_phase)
      M_IDLE, M_OVER: if (start) begin
        m_phase = M_GAP; m_frames = 0; m_lives = LIVES; m_score = '0;
      end
      M_GAP: if (edge_tick) begin
        m_frames++;
        if (m_frames == GAP) begin
          m_lane = pick_lane(); m_frames = 0; m_phase = M_ACT;
        end
      end
      M_ACT: begin
        if (hit) begin
          if (m_lives > 0) m_lives--;
          m_frames = 0; m_phase = M_HOLD;
        end else if (edge_tick) begin
          m_frames++;
          if (m_frames == ACT) begin
            if (m_score != 16'hFFFF) m_score++;
            m_frames = 0; m_phase = M_GAP;
          end
        end
      end
      M_HOLD: if (edge_tick) begin
        m_frames++;
        if (m_frames == HOLD) begin
          m_frames = 0;
          m_phase = (m_lives == 0) ? M_OVER : M_GAP;
        end
      end
      default: ;
    endcase
    m_active = nxt_active;
    m_go     = nxt_go;
    m_lfsr   = (m_lfsr >> 1) ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
    m_edge++;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    check("active", 32'(o_active), m_active);
    check("lives", 32'(o_lives), m_lives);
    check("score", 32'(o_score), 32'(m_score));
    check("game_over", 32'(o_game_over), m_go);
    check("state", 32'(o_state), 32'(m_phase));
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    check_all();
    if (vs_left == 0) begin
      v_sync  = ~v_sync;
      vs_left = vs_fixed ? 3 : (v_sync ? $urandom_range(2, 4) : $urandom_range(2, 5));
    end else begin
      vs_left--;
    end
  endtask

  // Identical timing from reset release each time so the LFSR-derived first lane repeats.
  task automatic bringup();
    rst_n = 1'b0; hit = 1'b0; start = 1'b0; v_sync = 1'b0;
    vs_fixed = 1'b1; vs_left = 3;
    model_reset();
    repeat (3) cyc();
    rst_n = 1'b1;
    repeat (2) cyc();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  initial begin
    int unsigned budget, t0, act_ticks, first_lane;
    logic [1:0]  pre, prev_lane;
    bit          counting;

    // Reset and start
    rst_n = 1'b0; hit = 1'b0; start = 1'b0; v_sync = 1'b0;
    vs_fixed = 1'b1; vs_left = 3;
    model_reset();
    repeat (3) cyc();
    check("rst_active", 32'(o_active), 0);
    check("rst_lives", 32'(o_lives), 0);
    check("rst_score", 32'(o_score), 0);
    check("rst_game_over", 32'(o_game_over), 0);
    check("rst_state", 32'(o_state), 0);
    rst_n = 1'b1;
    repeat (2) cyc();
    start = 1'b1;
    cyc();
    start = 1'b0;
    check("start_lives", 32'(o_lives), 3);
    check("start_state", 32'(o_state), 1);
    t0 = tick_count;
    for (budget = 0; budget < 500 && o_active == 2'b00; budget++) cyc();
    check("first_lane_timeout", 32'(budget < 500), 1);
    check("first_lane_ticks", tick_count - t0, GAP);
    first_lane = m_lane;
    vs_fixed = 1'b0;

    // Clean passes: per-barrier active window and no repeated lanes
    counting = 1'b0; act_ticks = 0; prev_lane = o_active;
    for (budget = 0; budget < 4000 && o_score != 16'd5; budget++) begin
      pre = o_active;
      cyc();
      if (edge_tick && pre != 2'b00) act_ticks++;
      if (pre == 2'b00 && o_active != 2'b00) begin
        check("lane_differs", 32'(o_active != prev_lane), 1);
        prev_lane = o_active;
        counting = 1'b1;
        act_ticks = 0;
      end
      if (pre != 2'b00 && o_active == 2'b00 && counting)
        check("active_ticks", act_ticks, ACT);
    end
    check("score5_timeout", 32'(budget < 4000), 1);
    check("score5", 32'(o_score), 5);

    // Hit at the third tick of ACTIVE, flag held across the hold
    for (budget = 0; budget < 2000 && !(m_phase == M_ACT && m_frames == 3); budget++) cyc();
    check("hit_wait_timeout", 32'(budget < 2000), 1);
    hit = 1'b1;
    t0 = tick_count;
    cyc();
    check("hit_state", 32'(o_state), 3);
    check("hit_lives", 32'(o_lives), 2);
    cyc();
    check("hit_active_zero", 32'(o_active), 0);
    for (budget = 0; budget < 500 && tick_count - t0 < 5; budget++) cyc();
    hit = 1'b0;
    check("hit_lives_once", 32'(o_lives), 2);
    check("hit_score_kept", 32'(o_score), 5);
    check("hit_then_gap", 32'(o_state), 1);

    // Hit on the same edge as the final ACTIVE tick
    for (budget = 0; budget < 3000 &&
         !(m_phase == M_ACT && m_frames == ACT - 1 && tick_at.size() != 0 && tick_at[0] == m_edge);
         budget++) cyc();
    check("simul_wait_timeout", 32'(budget < 3000), 1);
    hit = 1'b1;
    cyc();
    hit = 1'b0;
    check("simul_lives", 32'(o_lives), 1);
    check("simul_score", 32'(o_score), 5);
    check("simul_state", 32'(o_state), 3);

    // Third hit leads to game over
    for (budget = 0; budget < 2000 && m_phase != M_ACT; budget++) cyc();
    hit = 1'b1;
    cyc();
    hit = 1'b0;
    for (budget = 0; budget < 500 && o_game_over != 1'b1; budget++) cyc();
    check("go_timeout", 32'(budget < 500), 1);
    check("go_lives", 32'(o_lives), 0);
    check("go_state", 32'(o_state), 4);
    repeat (30) begin
      hit = ($urandom_range(0, 3) == 0);
      cyc();
      check("go_active_zero", 32'(o_active), 0);
    end
    hit = 1'b0;
    start = 1'b1;
    cyc();
    start = 1'b0;
    check("restart_lives", 32'(o_lives), 3);
    check("restart_score", 32'(o_score), 0);
    cyc();
    check("restart_game_over", 32'(o_game_over), 0);

    // Random hits and starts under random frame timing
    repeat (3000) begin
      hit   = ($urandom_range(0, 99) < 3);
      start = ($urandom_range(0, 199) == 0);
      cyc();
    end
    hit = 1'b0; start = 1'b0;

    // Mid-game asynchronous reset, then identical bring-up
    if (m_phase == M_IDLE || m_phase == M_OVER) begin
      start = 1'b1;
      cyc();
      start = 1'b0;
    end
    for (budget = 0; budget < 2000 && o_active == 2'b00; budget++) cyc();
    check("mid_wait_timeout", 32'(budget < 2000), 1);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("mid_rst_active", 32'(o_active), 0);
    check("mid_rst_state", 32'(o_state), 0);
    check("mid_rst_lives", 32'(o_lives), 0);
    bringup();
    t0 = tick_count;
    for (budget = 0; budget < 500 && o_active == 2'b00; budget++) cyc();
    check("relane_timeout", 32'(budget < 500), 1);
    check("relane_ticks", tick_count - t0, GAP);
    check("relane_repeat", 32'(o_active), first_lane);
    repeat (5) cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
